// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates the game's work RAM port between the game CPU and the hiscore engine.
// The CPU is paused via pause_req/pause_ack before the hiscore engine is granted the port.
module hiscore_ram_arbiter #(
  parameter int unsigned HS_ADDRESSWIDTH = 10,
  parameter logic [15:0] PAUSE_TIMEOUT   = 16'hFFFF,
  parameter logic [3:0]  SETTLE_CYCLES   = 4'd2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hs_access,
  input  logic [HS_ADDRESSWIDTH-1:0] hs_address,
  input  logic [7:0]                 hs_data_in,
  input  logic                       hs_write,
  output logic [7:0]                 hs_data_out,
  input  logic [HS_ADDRESSWIDTH-1:0] cpu_address,
  input  logic [7:0]                 cpu_data_in,
  input  logic                       cpu_write,
  output logic [7:0]                 cpu_data_out,
  output logic [HS_ADDRESSWIDTH-1:0] ram_address,
  output logic [7:0]                 ram_data,
  output logic                       ram_we,
  input  logic [7:0]                 ram_q,
  output logic                       pause_req,
  input  logic                       pause_ack,
  output logic                       hs_grant,
  output logic                       timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    SETTLE   = 3'd2,
    GRANTED  = 3'd3,
    RELEASE  = 3'd4,
    DROPWAIT = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [15:0] timeout_cnt, timeout_cnt_next, timeout_inc;
  logic [3:0]  settle_cnt, settle_cnt_next;
  logic        timeout_set;
  logic        cpu_write_ok;

  // Saturating increment so a huge PAUSE_TIMEOUT can never wrap the wait count.
  assign timeout_inc = (timeout_cnt == 16'hFFFF) ? timeout_cnt : timeout_cnt + 16'd1;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_next       = state;
    timeout_cnt_next = timeout_cnt;
    settle_cnt_next  = settle_cnt;
    timeout_set      = 1'b0;
    unique case (state)
      IDLE: begin
        timeout_cnt_next = '0;
        if (hs_access) state_next = REQUEST;
      end
      REQUEST: begin
        if (!hs_access) begin
          state_next = RELEASE;
        end else if (pause_ack) begin
          settle_cnt_next = SETTLE_CYCLES;
          state_next      = SETTLE;
        end else begin
          timeout_cnt_next = timeout_inc;
          if (timeout_inc >= PAUSE_TIMEOUT) begin
            timeout_set = 1'b1;
            state_next  = DROPWAIT;
          end
        end
      end
      SETTLE: begin
        if (!hs_access)            state_next = RELEASE;
        else if (settle_cnt == '0) state_next = GRANTED;
        else                       settle_cnt_next = settle_cnt - 4'd1;
      end
      GRANTED:  if (!hs_access) state_next = RELEASE;
      RELEASE:  state_next = IDLE;
      // A timed-out request must see hs_access low before a new attempt starts.
      DROPWAIT: if (!hs_access) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timeout_cnt <= '0;
      settle_cnt  <= '0;
      timeout_err <= 1'b0;
      hs_data_out <= 8'h00;
    end else begin
      state       <= state_next;
      timeout_cnt <= timeout_cnt_next;
      settle_cnt  <= settle_cnt_next;
      if (timeout_set) timeout_err <= 1'b1;
      if (hs_grant)    hs_data_out <= ram_q;
    end
  end

  assign hs_grant     = (state == GRANTED);
  assign pause_req    = (state == REQUEST) || (state == SETTLE) ||
                        (state == GRANTED) || (state == RELEASE);
  assign cpu_write_ok = (state == IDLE) || (state == DROPWAIT);

  // Port mux follows the registered state only, never the live request inputs.
  assign ram_address  = hs_grant ? hs_address : cpu_address;
  assign ram_data     = hs_grant ? hs_data_in : cpu_data_in;
  assign ram_we       = hs_grant ? hs_write   : (cpu_write & cpu_write_ok);
  assign cpu_data_out = ram_q;

endmodule
